// File: rtl/md_scheduler_if.sv
// Port bundle between the EX stage / hazard unit and the multiply/divide scheduler.
// The master drives the EX/ID md operations and operands; the slave returns status and HI/LO.
interface md_scheduler_if;
   logic [3:0]  mdOp_E;
   logic [31:0] A_E;
   logic [31:0] B_E;
   logic [3:0]  mdOp_D;
   logic        start;
   logic        busy;
   logic        md_stall;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] md_rdata;

   modport master (output mdOp_E, A_E, B_E, mdOp_D,
                   input  start, busy, md_stall, HI, LO, md_rdata);
   modport slave  (input  mdOp_E, A_E, B_E, mdOp_D,
                   output start, busy, md_stall, HI, LO, md_rdata);
endinterface

// File: rtl/md_scheduler.sv
// Fixed-latency mult/div unit owning HI/LO, plus the ID-stage stall request for md instructions.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu (codes 9-12); otherwise those codes act as none.
module md_scheduler #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic          clk,
   input  logic          reset,
   md_scheduler_if.slave md
);
   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MFHI  = 4'd5;
   localparam logic [3:0] OP_MFLO  = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;
   localparam logic [3:0] OP_MADD  = 4'd9;
   localparam logic [3:0] OP_MADDU = 4'd10;
   localparam logic [3:0] OP_MSUB  = 4'd11;
   localparam logic [3:0] OP_MSUBU = 4'd12;
   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

   logic        r_busy;
   logic [3:0]  r_cnt;
   logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
   logic        r_pend_wr;

   logic        w_start, w_d_md, w_res_wr;
   logic [3:0]  w_cnt_load;
   logic [63:0] w_res, w_acc, w_a_s, w_b_s, w_a_u, w_b_u, w_prod_s, w_prod_u;
   logic        w_a_neg, w_b_neg;
   logic [31:0] w_a_mag, w_b_mag, w_den_s, w_den_u, w_uq, w_ur, w_quo_s, w_rem_s;

   assign w_acc    = {r_hi, r_lo};
   assign w_a_s    = {{32{md.A_E[31]}}, md.A_E};
   assign w_b_s    = {{32{md.B_E[31]}}, md.B_E};
   assign w_a_u    = {32'd0, md.A_E};
   assign w_b_u    = {32'd0, md.B_E};
   assign w_prod_s = w_a_s * w_b_s;
   assign w_prod_u = w_a_u * w_b_u;

   // Signed divide on magnitudes; this also gives 0x80000000 / -1 = 0x80000000 without overflow.
   assign w_a_neg = md.A_E[31];
   assign w_b_neg = md.B_E[31];
   assign w_a_mag = w_a_neg ? (32'd0 - md.A_E) : md.A_E;
   assign w_b_mag = w_b_neg ? (32'd0 - md.B_E) : md.B_E;
   assign w_den_s = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
   assign w_den_u = (md.B_E == 32'd0) ? 32'd1 : md.B_E;
   assign w_uq    = w_a_mag / w_den_s;
   assign w_ur    = w_a_mag % w_den_s;
   assign w_quo_s = (w_a_neg ^ w_b_neg) ? (32'd0 - w_uq) : w_uq;
   assign w_rem_s = w_a_neg ? (32'd0 - w_ur) : w_ur;

   // Classify the EX and ID operations.
   always_comb begin
      w_start = 1'b0;
      w_d_md  = 1'b0;
      case (md.mdOp_E)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_start = 1'b1;
`ifdef MD_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_start = 1'b1;
`endif
         default: w_start = 1'b0;
      endcase
      case (md.mdOp_D)
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
         OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: w_d_md = 1'b1;
`ifdef MD_MADD_EN
         OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: w_d_md = 1'b1;
`endif
         default: w_d_md = 1'b0;
      endcase
   end

   // Result and latency for the compute op in EX.
   always_comb begin
      w_res      = w_acc;
      w_res_wr   = 1'b1;
      w_cnt_load = MULT_LOAD;
      case (md.mdOp_E)
         OP_MULT:  w_res = w_prod_s;
         OP_MULTU: w_res = w_prod_u;
         OP_DIV: begin
            w_res      = {w_rem_s, w_quo_s};
            w_res_wr   = (md.B_E != 32'd0);
            w_cnt_load = DIV_LOAD;
         end
         OP_DIVU: begin
            w_res      = {md.A_E % w_den_u, md.A_E / w_den_u};
            w_res_wr   = (md.B_E != 32'd0);
            w_cnt_load = DIV_LOAD;
         end
`ifdef MD_MADD_EN
         OP_MADD:  w_res = w_acc + w_prod_s;
         OP_MADDU: w_res = w_acc + w_prod_u;
         OP_MSUB:  w_res = w_acc - w_prod_s;
         OP_MSUBU: w_res = w_acc - w_prod_u;
`endif
         default: begin
            w_res    = w_acc;
            w_res_wr = 1'b0;
         end
      endcase
   end

   // Busy counter, pending result and HI/LO; EX md ops arriving while busy are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy    <= 1'b0;
         r_cnt     <= 4'd0;
         r_hi      <= 32'd0;
         r_lo      <= 32'd0;
         r_pend_hi <= 32'd0;
         r_pend_lo <= 32'd0;
         r_pend_wr <= 1'b0;
      end else if (r_busy) begin
         if (r_cnt == 4'd1) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            if (r_pend_wr) begin
               r_hi <= r_pend_hi;
               r_lo <= r_pend_lo;
            end
         end else begin
            r_cnt <= r_cnt - 4'd1;
         end
      end else if (w_start) begin
         r_busy    <= 1'b1;
         r_cnt     <= w_cnt_load;
         r_pend_hi <= w_res[63:32];
         r_pend_lo <= w_res[31:0];
         r_pend_wr <= w_res_wr;
      end else if (md.mdOp_E == OP_MTHI) begin
         r_hi <= md.A_E;
      end else if (md.mdOp_E == OP_MTLO) begin
         r_lo <= md.A_E;
      end
   end

   // Move-from read port.
   always_comb begin
      case (md.mdOp_E)
         OP_MFHI: md.md_rdata = r_hi;
         OP_MFLO: md.md_rdata = r_lo;
         default: md.md_rdata = 32'd0;
      endcase
   end

   assign md.start    = w_start;
   assign md.busy     = r_busy;
   assign md.md_stall = w_d_md && (w_start || r_busy);
   assign md.HI       = r_hi;
   assign md.LO       = r_lo;
endmodule
